fix2flt_seq: RTL and testbench
==============================

# fix2flt_seq

Sequential converter from 16-bit sign-and-magnitude fixed point (1 sign bit, 15-bit magnitude scaled by 2^FRAC_BITS) to IEEE-754 half precision. It is the return path for the float-to-fixed conversion used in Program 2. The block normalizes by shifting one bit per cycle, truncates without rounding, and reports completion with a start/done handshake compatible with the TopLevel harness.

## Interface
- FRAC_BITS, 8: position of the binary point in the magnitude. The magnitude is 7.8 at the default.
- EXP_BIAS, 15: half-precision exponent bias.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. Asserting low clears all state immediately.
- start  in  1  request pulse. Sampled only in IDLE.
- fix_in  in  16  operand, {sign, mag[14:0]}. Captured on the edge where start is accepted.
- busy  out  1  high from the capture edge until done is asserted.
- done  out  1  registered one-cycle completion pulse.
- flt_out  out  16  result {sign, exp[4:0], frac[9:0]}. Holds its value until the next completion.

## Operation
- States: IDLE, NORM, PACK, DONE.
- IDLE:
  - On start=1, capture sgn=fix_in[15] and mag=fix_in[14:0].
  - Set e = 14 - FRAC_BITS + EXP_BIAS (21 at the defaults).
  - Set busy=1 and go to NORM.
- NORM, evaluated each cycle:
  - If mag==0 or mag[14]==1, go to PACK.
  - Otherwise mag <= mag<<1, e <= e-1, and stay in NORM.
- PACK:
  - If mag==0: flt_out <= {sgn, 15'b0}. Negative zero (0x8000) maps to 0x8000.
  - Otherwise: flt_out <= {sgn, e[4:0], mag[13:4]}. The hidden bit is dropped and mag[3:0] is discarded (truncation toward zero).
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - start in this cycle is ignored; it is accepted only in IDLE.
- Width and range rules:
  - The leading one at magnitude bit k gives e = k - FRAC_BITS + EXP_BIAS, which lies in 7..21 at the defaults.
  - The result is never subnormal, infinite or NaN for any 16-bit input, so no saturation logic is needed.
  - e is a 5-bit register and never underflows.
- start while busy is ignored. fix_in changes after capture have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, flt_out=16'h0000, internal mag/e/sgn=0.
- Latency depends on the normalization shift count s = 14 - k (s=0 when mag==0).
- Counting the capture edge as edge 0:
  - edges 1..s perform the shifts;
  - edge s+1 enters PACK;
  - edge s+2 registers flt_out, asserts done and enters DONE.
- done is visible for the cycle following edge s+2. flt_out is valid in that same cycle.
- Latency bounds: minimum 2 cycles (mag==0 or mag[14]==1); maximum 16 cycles (mag==1).
- The earliest next start is accepted on the edge after DONE, so back-to-back throughput is one result per s+4 cycles.
- Reset asserted mid-operation:
  - outputs return to reset values asynchronously;
  - the pending conversion is abandoned and no done is produced;
  - after reset deasserts, the block waits in IDLE for a new start.

## Test plan
- fix_in=0x0100 (1.0) -> flt_out=0x3C00. done 8 cycles after capture. busy high for those 8 cycles.
- fix_in=0x0180 (1.5) -> 0x3E00. fix_in=0x8280 (-2.5) -> 0xC100. fix_in=0x0101 -> 0x3C04.
- Extremes:
  - fix_in=0x0001 -> 0x1C00 with 16-cycle latency.
  - fix_in=0x7FFF -> 0x57FF (low 4 bits truncated) with 2-cycle latency.
- Zeros: fix_in=0x0000 -> 0x0000 and fix_in=0x8000 -> 0x8000, each with 2-cycle latency.
- Busy and hold behaviour:
  - Start 0x0001, then pulse start with fix_in=0x0100 at cycle 5. The second start is ignored; the result is 0x1C00 with exactly one done pulse.
  - Hold start high through DONE. The next capture occurs only in IDLE.
- Reset at cycle 4 of a 0x0001 conversion:
  - busy, done and flt_out go to 0 immediately and no done follows.
  - A subsequent start with 0x0180 yields 0x3E00.

Source files
------------

// File: rtl/fix2flt_seq_if.sv
// fix2flt_seq_if
//   Start/done handshake and data bus for the fixed-to-half converter.
//   Ports carried:
//     start   - request pulse from the requester
//     fix_in  - 16-bit sign-magnitude operand {sign, mag[14:0]}
//     busy    - converter is working on a captured operand
//     done    - one-cycle completion pulse
//     flt_out - IEEE-754 half-precision result
//   master: the requester (drives start/fix_in)
//   slave : the converter (drives busy/done/flt_out)
interface fix2flt_seq_if;
    logic        start;
    logic [15:0] fix_in;
    logic        busy;
    logic        done;
    logic [15:0] flt_out;

    modport master (
        output start,
        output fix_in,
        input  busy,
        input  done,
        input  flt_out
    );

    modport slave (
        input  start,
        input  fix_in,
        output busy,
        output done,
        output flt_out
    );
endinterface

// File: rtl/fix2flt_seq.sv
// fix2flt_seq
//   Sequential converter from 16-bit sign-magnitude fixed point (15-bit
//   magnitude scaled by 2^FRAC_BITS) to IEEE-754 half precision.
//   Normalizes one bit per cycle, truncates the fraction, and signals
//   completion with a registered one-cycle done pulse.
//   Ports:
//     clk   - single clock, rising-edge active
//     reset - asynchronous, active-low; clears all state
//     bus   - fix2flt_seq_if.slave (start, fix_in, busy, done, flt_out)
module fix2flt_seq #(
    parameter int FRAC_BITS = 8,
    parameter int EXP_BIAS  = 15
) (
    input  logic          clk,
    input  logic          reset,
    fix2flt_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    // Exponent for a leading one at magnitude bit 14; each shift lowers it by one.
    localparam logic [4:0] E_INIT = 5'(14 - FRAC_BITS + EXP_BIAS);

    state_t      state_q, state_d;
    logic        sgn_q,   sgn_d;
    logic [14:0] mag_q,   mag_d;
    logic [4:0]  e_q,     e_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [15:0] flt_q,   flt_d;

    // Build the half-precision word from the normalized magnitude. The hidden
    // bit mag[14] is dropped and mag[3:0] discarded (truncation toward zero).
    function automatic logic [15:0] pack_half(input logic       s,
                                              input logic [4:0]  e,
                                              input logic [14:0] m);
        if (m == 15'd0) begin
            pack_half = {s, 15'd0};
        end else begin
            pack_half = {s, e, m[13:4]};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        mag_d   = mag_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        flt_d   = flt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sgn_d   = bus.fix_in[15];
                    mag_d   = bus.fix_in[14:0];
                    e_d     = E_INIT;
                    busy_d  = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if ((mag_q == 15'd0) || mag_q[14]) begin
                    state_d = PACK;
                end else begin
                    mag_d = {mag_q[13:0], 1'b0};
                    e_d   = e_q - 5'd1;
                end
            end
            PACK: begin
                flt_d   = pack_half(sgn_q, e_q, mag_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                // start is deliberately not sampled here
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            mag_q   <= 15'd0;
            e_q     <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            mag_q   <= mag_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flt_q   <= flt_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.flt_out = flt_q;

endmodule

// File: tb/tb_fix2flt_seq.sv
// tb_fix2flt_seq
//   Directed, table-driven bench for fix2flt_seq with hand-computed
//   half-precision results and latencies, plus sequences for start-while-busy,
//   start held through DONE, and reset during a conversion.
module tb_fix2flt_seq;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fix2flt_seq_if bus ();

    fix2flt_seq #(
        .FRAC_BITS (8),
        .EXP_BIAS  (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fix;
        logic [15:0] flt;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One conversion: start for one cycle, then scramble fix_in to show it is
    // not re-read. Checks latency, result, busy throughout, and pulse width.
    task automatic run_conv(input logic [15:0] fx, input logic [15:0] ef,
                            input int el, input string nm);
        int   lat;
        logic busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fix_in = fx;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.fix_in = ~fx;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_flt"}, bus.flt_out, ef);
        chk({nm, "_busy_during"}, busy_ok, 1'b1);
        chk({nm, "_busy_at_done"}, bus.busy, 1'b0);
        @(negedge clk);
        chk({nm, "_done_width"}, bus.done, 1'b0);
        chk({nm, "_flt_hold"}, bus.flt_out, ef);
    endtask

    initial begin
        int          cnt;
        int          first;
        logic [15:0] fl;
        logic [15:0] fl2;
        logic [15:0] fl6;
        logic [8:0]  mask;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'h0100, 16'h3C00, 8};
        vecs[1] = '{16'h0180, 16'h3E00, 8};
        vecs[2] = '{16'h8280, 16'hC100, 7};
        vecs[3] = '{16'h0101, 16'h3C04, 8};
        vecs[4] = '{16'h0001, 16'h1C00, 16};
        vecs[5] = '{16'h7FFF, 16'h57FF, 2};
        vecs[6] = '{16'h0000, 16'h0000, 2};
        vecs[7] = '{16'h8000, 16'h8000, 2};

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.fix_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_flt", bus.flt_out, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_conv(vecs[v].fix, vecs[v].flt, vecs[v].lat, $sformatf("vec%0d", v));
        end

        // start pulsed while busy must be ignored
        cnt   = 0;
        first = 0;
        fl    = 16'h0000;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fix_in = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (bus.done) begin
                cnt++;
                if (cnt == 1) begin
                    first = i;
                    fl    = bus.flt_out;
                end
            end
            if (i == 5) begin
                bus.start  = 1'b1;
                bus.fix_in = 16'h0100;
            end
            if (i == 6) bus.start = 1'b0;
        end
        chk("busy_ign_count", cnt, 1);
        chk("busy_ign_lat", first, 16);
        chk("busy_ign_flt", fl, 16'h1C00);

        // start held high through DONE: recapture only once back in IDLE
        mask = '0;
        fl2  = 16'hFFFF;
        fl6  = 16'hFFFF;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fix_in = 16'h7FFF;
        @(negedge clk);
        bus.fix_in = 16'h0000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            mask[i] = bus.done;
            if (i == 2) fl2 = bus.flt_out;
            if (i == 6) begin
                fl6       = bus.flt_out;
                bus.start = 1'b0;
            end
        end
        chk("hold_done_mask", mask, 9'b0_0100_0100);
        chk("hold_flt_first", fl2, 16'h57FF);
        chk("hold_flt_second", fl6, 16'h0000);
        repeat (3) @(negedge clk);

        // reset in the middle of a long conversion
        run_conv(16'h7FFF, 16'h57FF, 2, "pre_rst");
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fix_in = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_flt", bus.flt_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        chk("midrst_idle_busy", bus.busy, 1'b0);
        run_conv(16'h0180, 16'h3E00, 8, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
